// File: rtl/dcache_dm_wb.sv
// -----------------------------------------------------------------------------
// dcache_dm_wb : direct-mapped, write-back, write-allocate data cache.
//
// Sits between the pipeline Memory stage and main memory. Hits complete in
// the cycle they are presented. A miss stalls the requester while the victim
// block is written back (only when dirty) and the new block is filled. Once
// the fill is done, the held request completes as a hit in IDLE.
//
// Parameters
//   INDEX_W : index bits; 2**INDEX_W blocks of 4 x 32-bit words
//   TAG_W   : tag bits; must equal 28 - INDEX_W
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   proc_ren/wen   : read / write request (both set is treated as a write)
//   proc_addr[29:0]: word address {tag, index, offset[1:0]}
//   proc_wdata     : write data
//   proc_stall     : request not complete this cycle (combinational)
//   proc_rdata     : read data, valid when proc_ren=1 and proc_stall=0
//   mem_read/write : block read / write request to memory
//   mem_addr[27:0] : block address
//   mem_wdata/rdata: 128-bit block, word 0 in [31:0]
//   mem_ready      : one-cycle completion pulse from memory
//   hit_cnt/miss_cnt: performance counters
//
// Optional feature
//   DCACHE_PERF_CNT_EN : when defined, hit_cnt/miss_cnt count hits and misses;
//                        when undefined both outputs are tied to zero.
// -----------------------------------------------------------------------------
module dcache_dm_wb #(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_ren,
  input  logic         proc_wen,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
);

  localparam int NB = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  // Pick one 32-bit word out of a 128-bit block.
  function automatic logic [31:0] get_word(input logic [127:0] line,
                                           input logic [1:0]   off);
    logic [31:0] w;
    case (off)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      2'd3:    w = line[127:96];
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // Return a copy of a block with one word replaced.
  function automatic logic [127:0] put_word(input logic [127:0] line,
                                            input logic [1:0]   off,
                                            input logic [31:0]  w);
    logic [127:0] l;
    l = line;
    case (off)
      2'd0:    l[31:0]   = w;
      2'd1:    l[63:32]  = w;
      2'd2:    l[95:64]  = w;
      2'd3:    l[127:96] = w;
      default: l = line;
    endcase
    return l;
  endfunction

  // Storage
  logic [NB-1:0]    r_valid;
  logic [NB-1:0]    r_dirty;
  logic [TAG_W-1:0] r_tag  [NB];
  logic [127:0]     r_data [NB];

  state_t r_state;
  state_t w_next_state;

  // Address decode and hit detection
  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [1:0]         w_off;
  logic [127:0]       w_line;
  logic [127:0]       w_line_merged;
  logic               w_hit;
  logic               w_req;
  logic               w_wr;
  logic               w_rd;
  logic               w_idle;

  assign w_idx         = proc_addr[INDEX_W+1:2];
  assign w_tag         = proc_addr[29:INDEX_W+2];
  assign w_off         = proc_addr[1:0];
  assign w_line        = r_data[w_idx];
  assign w_line_merged = put_word(w_line, w_off, proc_wdata);
  assign w_hit         = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_req         = proc_ren | proc_wen;
  assign w_wr          = proc_wen;
  assign w_rd          = proc_ren & ~proc_wen;
  assign w_idle        = (r_state == S_IDLE);

  // State register; reset abandons any in-flight memory transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req && !w_hit) begin
          if (r_valid[w_idx] && r_dirty[w_idx]) begin
            w_next_state = S_WRITEBACK;
          end else begin
            w_next_state = S_ALLOCATE;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          w_next_state = S_ALLOCATE;
        end else begin
          w_next_state = S_WRITEBACK;
        end
      end
      S_ALLOCATE: begin
        if (mem_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_ALLOCATE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: memory strobes come from the state alone, so they can
  // never be asserted together.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 28'd0;
    mem_wdata  = 128'd0;
    proc_stall = 1'b0;
    proc_rdata = 32'd0;
    case (r_state)
      S_IDLE: begin
        // rst_n gate keeps stall low while reset is held with a request up.
        proc_stall = w_req & ~w_hit & rst_n;
        if (w_rd && w_hit) begin
          proc_rdata = get_word(w_line, w_off);
        end else begin
          proc_rdata = 32'd0;
        end
      end
      S_WRITEBACK: begin
        mem_write  = 1'b1;
        mem_addr   = {r_tag[w_idx], w_idx};
        mem_wdata  = w_line;
        proc_stall = 1'b1;
      end
      S_ALLOCATE: begin
        mem_read   = 1'b1;
        mem_addr   = proc_addr[29:2];
        proc_stall = 1'b1;
      end
      default: begin
        proc_stall = 1'b0;
      end
    endcase
  end

  // Valid/dirty bits: write hit dirties the line, a fill installs it clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_idle && w_wr && w_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end else if ((r_state == S_ALLOCATE) && mem_ready) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end
  end

  // Data and tag arrays; contents are don't-care until valid is set.
  always_ff @(posedge clk) begin
    if (w_idle && w_wr && w_hit) begin
      r_data[w_idx] <= w_line_merged;
    end else if ((r_state == S_ALLOCATE) && mem_ready) begin
      r_data[w_idx] <= mem_rdata;
      r_tag[w_idx]  <= w_tag;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        r_after_miss;
  logic        w_done;
  logic        w_miss_start;

  assign w_done       = w_idle & w_req & w_hit;
  assign w_miss_start = w_idle & w_req & ~w_hit;

  // Counters: the completion that follows a fill is not counted as a hit,
  // r_after_miss remembers that the current request already stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt    <= 32'd0;
      r_miss_cnt   <= 32'd0;
      r_after_miss <= 1'b0;
    end else if (w_done) begin
      if (!r_after_miss) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      r_after_miss <= 1'b0;
    end else if (w_miss_start) begin
      r_miss_cnt   <= r_miss_cnt + 32'd1;
      r_after_miss <= 1'b1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule
